// File: rtl/pipeline_debug_ctrl_if.sv
// pipeline_debug_ctrl_if: command/status bundle between the host debug unit and the pipeline run/step controller
interface pipeline_debug_ctrl_if #(parameter int CNT_W = 32, parameter int STEP_W = 8);
  logic              cmd_valid;
  logic [2:0]        cmd_code;
  logic [STEP_W-1:0] cmd_arg;
  logic              halt_retired;
  logic              cmd_ready;
  logic              pipe_enable;
  logic              pipe_reset;
  logic [2:0]        state_out;
  logic [CNT_W-1:0]  cycle_count;
  logic              done;
  modport master (output cmd_valid, cmd_code, cmd_arg, halt_retired,
                  input  cmd_ready, pipe_enable, pipe_reset, state_out, cycle_count, done);
  modport slave  (input  cmd_valid, cmd_code, cmd_arg, halt_retired,
                  output cmd_ready, pipe_enable, pipe_reset, state_out, cycle_count, done);
endinterface

// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: run/step/halt/clear sequencer driving the pipeline latches' debug enable and reset
module pipeline_debug_ctrl #(
  parameter int CNT_W      = 32,
  parameter int STEP_W     = 8,
  parameter int CLR_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_debug_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, CLEAR = 3'd3, FINISHED = 3'd4} state_t;
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  state_t            state_q, state_d;
  logic              pe_q, pe_d, pr_q, pr_d, done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic              acc, go_run, go_step, go_halt, go_clear;
  always_comb begin
    acc      = bus.cmd_valid && state_q != CLEAR;
    go_run   = acc && bus.cmd_code == 3'd1;
    go_step  = acc && bus.cmd_code == 3'd2;
    go_halt  = acc && bus.cmd_code == 3'd3;
    go_clear = acc && bus.cmd_code == 3'd4;
    state_d  = state_q;
    step_d   = step_q;
    clr_d    = clr_q == '0 ? '0 : clr_q - CLR_W'(1);
    done_d   = 1'b0;
    cnt_d    = (pe_q && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    unique case (state_q)
      IDLE: begin
        if (go_run) state_d = RUN;
        else if (go_step) begin
          state_d = STEP;
          step_d  = bus.cmd_arg == '0 ? STEP_W'(1) : bus.cmd_arg;
        end
        else if (go_clear) state_d = CLEAR;
      end
      RUN, STEP: begin
        if (state_q == STEP) step_d = step_q - STEP_W'(1);
        // CLEAR beats a retiring HALT, which beats a host HALT; CLEAR suppresses done
        if (go_clear) state_d = CLEAR;
        else if (bus.halt_retired) begin
          state_d = FINISHED;
          done_d  = 1'b1;
        end
        else if (go_halt || (state_q == STEP && step_q == STEP_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      CLEAR:    state_d = clr_q == '0 ? IDLE : CLEAR;
      FINISHED: state_d = go_clear ? CLEAR : FINISHED;
      default:  state_d = IDLE;
    endcase
    if (state_d != STEP) step_d = '0;
    if (state_d == CLEAR && state_q != CLEAR) clr_d = CLR_W'(CLR_CYCLES - 1);
    if (state_d == CLEAR) cnt_d = '0;
    pe_d = state_d == RUN || state_d == STEP;
    pr_d = state_d == CLEAR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pe_q    <= 1'b0;
      pr_q    <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      step_q  <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      pe_q    <= pe_d;
      pr_q    <= pr_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      clr_q   <= clr_d;
    end
  end
  assign bus.cmd_ready   = state_q != CLEAR;
  assign bus.pipe_enable = pe_q;
  assign bus.pipe_reset  = pr_q;
  assign bus.state_out   = state_q;
  assign bus.cycle_count = cnt_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb_pipeline_debug_ctrl: directed scenarios checked every cycle against a behavioural model, plus literal pins
module tb_pipeline_debug_ctrl;
  localparam int CNT_W = 4, STEP_W = 8, CLR_CYCLES = 2;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, reset = 1'b1;
  pipeline_debug_ctrl_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus();
  pipeline_debug_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int m_mode = 0, m_steps = 0, m_clr = 0, m_cnt = 0, code = 0;
  bit m_rp = 1'b1, m_done = 1'b0, started = 1'b0;
  int pe_seen = 0, pr_seen = 0, done_seen = 0;
  int s_pe, s_pr, s_done;

  task automatic chk(input string n, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  // Model: modes 0 idle,1 run,2 step,3 clear,4 finished; counts what each posedge must do
  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_steps = 0; m_clr = 0; m_cnt = 0; m_rp = 1'b1; m_done = 1'b0;
    end else begin
      code   = (bus.cmd_valid && m_mode != 3) ? int'(bus.cmd_code) : 0;
      m_rp   = 1'b0;
      m_done = 1'b0;
      if (m_mode == 1 || m_mode == 2) m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
      case (m_mode)
        0: begin
          if (code == 1) m_mode = 1;
          else if (code == 2) begin m_mode = 2; m_steps = bus.cmd_arg == 0 ? 1 : int'(bus.cmd_arg); end
          else if (code == 4) begin m_mode = 3; m_clr = CLR_CYCLES; m_cnt = 0; end
        end
        1, 2: begin
          if (code == 4) begin m_mode = 3; m_clr = CLR_CYCLES; m_cnt = 0; end
          else if (bus.halt_retired) begin m_mode = 4; m_done = 1'b1; end
          else if (code == 3) begin m_mode = 0; m_done = 1'b1; end
          else if (m_mode == 2) begin
            m_steps--;
            if (m_steps == 0) begin m_mode = 0; m_done = 1'b1; end
          end
        end
        3: begin m_clr--; if (m_clr == 0) m_mode = 0; end
        4: if (code == 4) begin m_mode = 3; m_clr = CLR_CYCLES; m_cnt = 0; end
        default: ;
      endcase
    end
    started = 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (started) begin
      chk("state_out", bus.state_out, m_mode);
      chk("pipe_enable", bus.pipe_enable, (m_mode == 1 || m_mode == 2));
      chk("pipe_reset", bus.pipe_reset, (m_rp || m_mode == 3));
      chk("cmd_ready", bus.cmd_ready, m_mode != 3);
      chk("cycle_count", bus.cycle_count, m_cnt);
      chk("done", bus.done, m_done);
      chk("done_with_reset", bus.done && bus.pipe_reset, 0);
      pe_seen   += int'(bus.pipe_enable);
      pr_seen   += int'(bus.pipe_reset);
      done_seen += int'(bus.done);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input int c, input int arg);
    bus.cmd_valid = 1'b1; bus.cmd_code = 3'(c); bus.cmd_arg = STEP_W'(arg);
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_code = 3'd0; bus.cmd_arg = '0;
  endtask

  task automatic snap;
    s_pe = pe_seen; s_pr = pr_seen; s_done = done_seen;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_code = 3'd0; bus.cmd_arg = '0; bus.halt_retired = 1'b0;
    cyc(3);
    reset = 1'b0;
    chk("pin_reset_pr_after_release", bus.pipe_reset, 1);
    cyc(1);
    chk("pin_reset_pr_drops", bus.pipe_reset, 0);
    cyc(4);
    chk("pin_idle_pe", bus.pipe_enable, 0);
    chk("pin_idle_cnt", bus.cycle_count, 0);
    // STEP 3
    snap(); cmd(2, 3); cyc(5);
    chk("pin_step3_enabled", pe_seen - s_pe, 3);
    chk("pin_step3_done", done_seen - s_done, 1);
    chk("pin_step3_state", bus.state_out, 0);
    chk("pin_step3_cnt", bus.cycle_count, 3);
    // CLEAR, then STEP 0
    snap(); cmd(4, 0); cyc(3);
    chk("pin_clear_pr_cycles", pr_seen - s_pr, 2);
    chk("pin_clear_cnt", bus.cycle_count, 0);
    snap(); cmd(2, 0); cyc(3);
    chk("pin_step0_enabled", pe_seen - s_pe, 1);
    chk("pin_step0_cnt", bus.cycle_count, 1);
    // RUN offered while clearing is not consumed
    cmd(4, 0); cmd(1, 0); cyc(3);
    chk("pin_cmd_in_clear_dropped", bus.state_out, 0);
    // RUN then HALT retires on the 10th enabled edge
    snap(); cmd(1, 0); cyc(9);
    bus.halt_retired = 1'b1; cyc(1); bus.halt_retired = 1'b0;
    chk("pin_halt_cnt", bus.cycle_count, 10);
    chk("pin_halt_state", bus.state_out, 4);
    chk("pin_halt_pe", bus.pipe_enable, 0);
    chk("pin_halt_done", done_seen - s_done, 1);
    cmd(1, 0); cmd(2, 2); bus.halt_retired = 1'b1; cyc(1); bus.halt_retired = 1'b0; cyc(1);
    chk("pin_finished_ignores", bus.state_out, 4);
    snap(); cmd(4, 0); cyc(3);
    chk("pin_fin_clear_pr", pr_seen - s_pr, 2);
    chk("pin_fin_clear_cnt", bus.cycle_count, 0);
    chk("pin_fin_clear_state", bus.state_out, 0);
    // CLEAR and halt_retired together in RUN
    cmd(1, 0); cyc(3); snap();
    bus.halt_retired = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_code = 3'd4;
    cyc(1);
    bus.halt_retired = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_code = 3'd0;
    chk("pin_clear_wins_state", bus.state_out, 3);
    chk("pin_clear_wins_nodone", done_seen - s_done, 0);
    cyc(3);
    // HALT cmd and halt_retired together in STEP
    cmd(2, 5); cyc(1); snap();
    bus.halt_retired = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_code = 3'd3;
    cyc(1);
    bus.halt_retired = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_code = 3'd0;
    chk("pin_retire_beats_halt", bus.state_out, 4);
    chk("pin_retire_one_done", done_seen - s_done, 1);
    cmd(4, 0); cyc(3);
    // RUN stopped by host HALT
    cmd(1, 0); cyc(2); snap(); cmd(3, 0);
    chk("pin_host_halt_state", bus.state_out, 0);
    chk("pin_host_halt_done", done_seen - s_done, 1);
    // reset mid-run
    cmd(1, 0); cyc(4); reset = 1'b1; cyc(1);
    chk("pin_midreset_pe", bus.pipe_enable, 0);
    chk("pin_midreset_cnt", bus.cycle_count, 0);
    chk("pin_midreset_state", bus.state_out, 0);
    reset = 1'b0; cyc(2);
    // saturation
    cmd(1, 0); cyc(30);
    chk("pin_saturate", bus.cycle_count, 15);
    cmd(3, 0); cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
